// File: rtl/wb_scoreboard_arbiter_if.sv
// Bus bundle for the write-back sequencer.
// Groups the issue-stage, write-back requester and regfile write-port signals.
interface wb_scoreboard_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned RFNUM = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned AW = $clog2(RFNUM);

  logic                 iss_valid;
  logic                 iss_wen;
  logic [AW-1:0]        iss_rd;
  logic                 iss_rd_src;
  logic [AW-1:0]        iss_rj;
  logic [AW-1:0]        iss_rk;
  logic                 iss_stall;

  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*AW-1:0]   wb_rd;
  logic [NREQ*DW-1:0]   wb_data;
  logic [NREQ-1:0]      wb_ready;

  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [AW:0]          pend_cnt;

  modport master (
    output iss_valid, iss_wen, iss_rd, iss_rd_src, iss_rj, iss_rk,
    output wb_valid, wb_rd, wb_data,
    input  iss_stall, wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
  );

  modport slave (
    input  iss_valid, iss_wen, iss_rd, iss_rd_src, iss_rj, iss_rk,
    input  wb_valid, wb_rd, wb_data,
    output iss_stall, wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
  );
endinterface

// File: rtl/wb_scoreboard_arbiter.sv
// Round-robin write-back arbiter onto the single GPR write port, with a per-register busy
// scoreboard that stalls issue on RAW/WAW hazards against in-flight writes.
module wb_scoreboard_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned RFNUM = 32,
  parameter int unsigned DW    = 32
) (
  input logic                    aclk,
  input logic                    reset,
  wb_scoreboard_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(RFNUM);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    idx, gnt_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  grant;
  logic [AW-1:0]    wb_rd_arr   [NREQ];
  logic [DW-1:0]    wb_data_arr [NREQ];

  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;

  logic [RFNUM-1:0] busy_q, busy_d, busy_eff, clr_vec, set_vec;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;
  logic             stall, fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wb_rd_arr[i]   = bus.wb_rd[i*AW +: AW];
    assign wb_data_arr[i] = bus.wb_data[i*DW +: DW];
  end

  // First valid requester at or after rr_ptr wins; nothing is granted during reset.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(rr_ptr_q) + k) % NREQ);
      if (!gnt_any && bus.wb_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (reset) gnt_any = 1'b0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
    rr_ptr_d = gnt_any ? PW'((32'(gnt_idx) + 1) % NREQ) : rr_ptr_q;
  end

  always_comb begin
    rf_we_d    = gnt_any;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_any) begin
      rf_waddr_d = wb_rd_arr[gnt_idx];
      rf_wdata_d = wb_data_arr[gnt_idx];
    end
  end

  // The register being written this cycle is forwarded, so it no longer counts as busy.
  always_comb begin
    clr_vec = '0;
    if (rf_we_q) clr_vec[rf_waddr_q] = 1'b1;
    busy_eff = busy_q & ~clr_vec;

    stall = bus.iss_valid &
            (((bus.iss_rj != '0) & busy_eff[bus.iss_rj]) |
             ((bus.iss_rk != '0) & busy_eff[bus.iss_rk]) |
             ((bus.iss_rd != '0) & (bus.iss_rd_src | bus.iss_wen) & busy_eff[bus.iss_rd]));
    fire  = bus.iss_valid & ~stall;

    set_vec = '0;
    if (fire && bus.iss_wen && (bus.iss_rd != '0)) set_vec[bus.iss_rd] = 1'b1;

    busy_d    = busy_eff | set_vec;
    busy_d[0] = 1'b0;

    pend_cnt_d = '0;
    for (int unsigned i = 0; i < RFNUM; i++) begin
      pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign bus.wb_ready  = grant;
  assign bus.iss_stall = stall;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pend_cnt  = pend_cnt_q;
endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Self-checking bench for wb_scoreboard_arbiter: directed scenarios plus a randomized run
// checked against a behavioural model of busy registers, round-robin order and the write port.
module tb_wb_scoreboard_arbiter;
  localparam int NREQ  = 3;
  localparam int RFNUM = 32;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  wb_scoreboard_arbiter_if #(.NREQ(NREQ), .RFNUM(RFNUM), .DW(DW)) bus ();

  wb_scoreboard_arbiter #(.NREQ(NREQ), .RFNUM(RFNUM), .DW(DW)) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of busy registers, rotating priority pointer, last write.
  bit          m_busy [RFNUM];
  int          m_rr;
  bit          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  function automatic int exp_grant();
    if (reset) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (bus.wb_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit exp_busy(int r);
    return (r != 0) && m_busy[r] && !(m_we && (int'(m_waddr) == r));
  endfunction

  function automatic bit exp_stall();
    return bus.iss_valid && (exp_busy(int'(bus.iss_rj)) || exp_busy(int'(bus.iss_rk)) ||
           ((bus.iss_rd_src || bus.iss_wen) && exp_busy(int'(bus.iss_rd))));
  endfunction

  function automatic int exp_pend();
    int n = 0;
    for (int i = 0; i < RFNUM; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(posedge aclk) begin
    if (reset) begin
      for (int i = 0; i < RFNUM; i++) m_busy[i] <= 1'b0;
      m_rr    <= 0;
      m_we    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
    end else begin
      if (m_we) m_busy[m_waddr] <= 1'b0;
      if (bus.iss_valid && !exp_stall() && bus.iss_wen && (bus.iss_rd != '0))
        m_busy[bus.iss_rd] <= 1'b1;
      m_we <= (exp_grant() >= 0);
      if (exp_grant() >= 0) begin
        m_waddr <= bus.wb_rd[exp_grant()*AW +: AW];
        m_wdata <= bus.wb_data[exp_grant()*DW +: DW];
        m_rr    <= (exp_grant() + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    bus.iss_valid  = 1'b0;
    bus.iss_wen    = 1'b0;
    bus.iss_rd     = '0;
    bus.iss_rd_src = 1'b0;
    bus.iss_rj     = '0;
    bus.iss_rk     = '0;
    bus.wb_valid   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.iss_valid = 1'b1;
    bus.iss_rj    = AW'(5);
    bus.wb_valid  = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.wb_rd[i*AW +: AW]   = AW'(i + 1);
      bus.wb_data[i*DW +: DW] = 32'h100 + i;
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      sample();
      n_cmp += 6;
      if (bus.wb_ready !== 3'b000) begin
        n_err++; $display("FAIL reset_wb_ready: got %b want 000", bus.wb_ready);
      end
      if (bus.rf_we !== 1'b0) begin
        n_err++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we);
      end
      if (bus.rf_waddr !== 5'd0) begin
        n_err++; $display("FAIL reset_rf_waddr: got %0d want 0", bus.rf_waddr);
      end
      if (bus.rf_wdata !== 32'd0) begin
        n_err++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata);
      end
      if (bus.pend_cnt !== 6'd0) begin
        n_err++; $display("FAIL reset_pend_cnt: got %0d want 0", bus.pend_cnt);
      end
      if (bus.iss_stall !== 1'b0) begin
        n_err++; $display("FAIL reset_iss_stall: got %b want 0", bus.iss_stall);
      end
    end
    tick();
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_raw();
    bus.iss_valid = 1'b1;
    bus.iss_wen   = 1'b1;
    bus.iss_rd    = AW'(5);
    sample();
    n_cmp++;
    if (bus.iss_stall !== 1'b0) begin
      n_err++; $display("FAIL raw_first_issue_stall: got %b want 0", bus.iss_stall);
    end
    tick();
    bus.iss_wen = 1'b0;
    bus.iss_rd  = '0;
    bus.iss_rj  = AW'(5);
    sample();
    n_cmp += 2;
    if (bus.iss_stall !== 1'b1) begin
      n_err++; $display("FAIL raw_stall: got %b want 1", bus.iss_stall);
    end
    if (bus.pend_cnt !== 6'd1) begin
      n_err++; $display("FAIL raw_pend_cnt: got %0d want 1", bus.pend_cnt);
    end
    tick();
    bus.wb_valid            = 3'b010;
    bus.wb_rd[1*AW +: AW]   = AW'(5);
    bus.wb_data[1*DW +: DW] = 32'hDEAD;
    sample();
    n_cmp += 2;
    if (bus.wb_ready !== 3'b010) begin
      n_err++; $display("FAIL raw_grant: got %b want 010", bus.wb_ready);
    end
    if (bus.iss_stall !== 1'b1) begin
      n_err++; $display("FAIL raw_stall_before_write: got %b want 1", bus.iss_stall);
    end
    tick();
    bus.wb_valid = '0;
    sample();
    n_cmp += 4;
    if (bus.rf_we !== 1'b1) begin
      n_err++; $display("FAIL raw_rf_we: got %b want 1", bus.rf_we);
    end
    if (bus.rf_waddr !== 5'd5) begin
      n_err++; $display("FAIL raw_rf_waddr: got %0d want 5", bus.rf_waddr);
    end
    if (bus.rf_wdata !== 32'hDEAD) begin
      n_err++; $display("FAIL raw_rf_wdata: got %h want 0000dead", bus.rf_wdata);
    end
    if (bus.iss_stall !== 1'b0) begin
      n_err++; $display("FAIL raw_forward_no_stall: got %b want 0", bus.iss_stall);
    end
    tick();
    idle_inputs();
    sample();
    n_cmp += 2;
    if (bus.pend_cnt !== 6'd0) begin
      n_err++; $display("FAIL raw_pend_cleared: got %0d want 0", bus.pend_cnt);
    end
    if (bus.rf_we !== 1'b0) begin
      n_err++; $display("FAIL raw_rf_we_drop: got %b want 0", bus.rf_we);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] want;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.wb_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.wb_rd[i*AW +: AW]   = AW'(10 + i);
      bus.wb_data[i*DW +: DW] = 32'hA0 + i;
    end
    for (int c = 0; c < 4; c++) begin
      sample();
      want = 3'b001 << (c % 3);
      n_cmp++;
      if (bus.wb_ready !== want) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b want %b", c, bus.wb_ready, want);
      end
      if (c > 0) begin
        n_cmp++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== AW'(10 + (c - 1) % 3)) begin
          n_err++;
          $display("FAIL rr_write_%0d: got we=%b addr=%0d want we=1 addr=%0d", c, bus.rf_we,
                   bus.rf_waddr, 10 + (c - 1) % 3);
        end
      end
      tick();
    end
    bus.wb_valid = '0;
    sample();
    n_cmp++;
    if (bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hA0) begin
      n_err++;
      $display("FAIL rr_last_write: got addr=%0d data=%h want addr=10 data=000000a0",
               bus.rf_waddr, bus.rf_wdata);
    end
    tick();
  endtask

  task automatic test_set_clear();
    bus.iss_valid = 1'b1;
    bus.iss_wen   = 1'b1;
    bus.iss_rd    = AW'(7);
    tick();
    idle_inputs();
    bus.wb_valid            = 3'b001;
    bus.wb_rd[0*AW +: AW]   = AW'(7);
    bus.wb_data[0*DW +: DW] = 32'h77;
    sample();
    n_cmp += 2;
    if (bus.wb_ready !== 3'b001) begin
      n_err++; $display("FAIL sc_grant: got %b want 001", bus.wb_ready);
    end
    if (bus.pend_cnt !== 6'd1) begin
      n_err++; $display("FAIL sc_pend_before: got %0d want 1", bus.pend_cnt);
    end
    tick();
    bus.wb_valid  = '0;
    bus.iss_valid = 1'b1;
    bus.iss_wen   = 1'b1;
    bus.iss_rd    = AW'(7);
    sample();
    n_cmp += 2;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin
      n_err++; $display("FAIL sc_write: got we=%b addr=%0d want we=1 addr=7", bus.rf_we,
                        bus.rf_waddr);
    end
    if (bus.iss_stall !== 1'b0) begin
      n_err++; $display("FAIL sc_issue_stall: got %b want 0", bus.iss_stall);
    end
    tick();
    idle_inputs();
    sample();
    n_cmp++;
    if (bus.pend_cnt !== 6'd1) begin
      n_err++; $display("FAIL sc_set_wins: got %0d want 1", bus.pend_cnt);
    end
    tick();
    bus.wb_valid = 3'b001;
    tick();
    bus.wb_valid = '0;
    tick();
    sample();
    n_cmp++;
    if (bus.pend_cnt !== 6'd0) begin
      n_err++; $display("FAIL sc_drain: got %0d want 0", bus.pend_cnt);
    end
    tick();
  endtask

  task automatic test_zero_waw();
    bus.iss_valid = 1'b1;
    bus.iss_wen   = 1'b1;
    bus.iss_rd    = '0;
    bus.iss_rj    = '0;
    bus.iss_rk    = '0;
    sample();
    n_cmp++;
    if (bus.iss_stall !== 1'b0) begin
      n_err++; $display("FAIL zero_stall: got %b want 0", bus.iss_stall);
    end
    tick();
    idle_inputs();
    sample();
    n_cmp++;
    if (bus.pend_cnt !== 6'd0) begin
      n_err++; $display("FAIL zero_pend: got %0d want 0", bus.pend_cnt);
    end
    tick();
    bus.iss_valid = 1'b1;
    bus.iss_wen   = 1'b1;
    bus.iss_rd    = AW'(9);
    sample();
    n_cmp++;
    if (bus.iss_stall !== 1'b0) begin
      n_err++; $display("FAIL waw_first: got %b want 0", bus.iss_stall);
    end
    tick();
    sample();
    n_cmp += 2;
    if (bus.iss_stall !== 1'b1) begin
      n_err++; $display("FAIL waw_second: got %b want 1", bus.iss_stall);
    end
    if (bus.pend_cnt !== 6'd1) begin
      n_err++; $display("FAIL waw_pend: got %0d want 1", bus.pend_cnt);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bus.iss_rd = AW'(11);
    tick();
    bus.iss_rd = AW'(12);
    tick();
    idle_inputs();
    bus.wb_valid            = 3'b001;
    bus.wb_rd[0*AW +: AW]   = AW'(20);
    bus.wb_data[0*DW +: DW] = 32'h5;
    sample();
    n_cmp += 2;
    if (bus.wb_ready !== 3'b001) begin
      n_err++; $display("FAIL mr_grant: got %b want 001", bus.wb_ready);
    end
    if (bus.pend_cnt !== 6'd3) begin
      n_err++; $display("FAIL mr_pend_before: got %0d want 3", bus.pend_cnt);
    end
    tick();
    bus.wb_valid = '0;
    reset        = 1'b1;
    sample();
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.pend_cnt !== 6'd3) begin
      n_err++; $display("FAIL mr_state_before: got we=%b pend=%0d want we=1 pend=3", bus.rf_we,
                        bus.pend_cnt);
    end
    tick();
    reset        = 1'b0;
    bus.wb_valid = 3'b111;
    sample();
    n_cmp += 3;
    if (bus.pend_cnt !== 6'd0) begin
      n_err++; $display("FAIL mr_pend_after: got %0d want 0", bus.pend_cnt);
    end
    if (bus.rf_we !== 1'b0) begin
      n_err++; $display("FAIL mr_rf_we_after: got %b want 0", bus.rf_we);
    end
    if (bus.wb_ready !== 3'b001) begin
      n_err++; $display("FAIL mr_rr_ptr_after: got %b want 001", bus.wb_ready);
    end
    tick();
    bus.wb_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int g;
    int g_prev = -1;
    logic [2:0] want;
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.iss_valid  = 1'($urandom_range(0, 1));
      bus.iss_wen    = 1'($urandom_range(0, 1));
      bus.iss_rd_src = ($urandom_range(0, 3) == 0);
      bus.iss_rd     = AW'($urandom_range(0, 7));
      bus.iss_rj     = AW'($urandom_range(0, 7));
      bus.iss_rk     = AW'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.wb_valid[i] || g_prev == i) begin
          bus.wb_valid[i]         = ($urandom_range(0, 2) == 0);
          bus.wb_rd[i*AW +: AW]   = AW'($urandom_range(0, 7));
          bus.wb_data[i*DW +: DW] = $urandom;
        end
      end
      sample();
      g    = exp_grant();
      want = (g >= 0) ? (3'b001 << g) : 3'b000;
      n_cmp += 4;
      if (bus.wb_ready !== want) begin
        n_err++; $display("FAIL rand_grant c=%0d: got %b want %b", c, bus.wb_ready, want);
      end
      if (bus.iss_stall !== exp_stall()) begin
        n_err++; $display("FAIL rand_stall c=%0d: got %b want %b", c, bus.iss_stall, exp_stall());
      end
      if (bus.rf_we !== m_we) begin
        n_err++; $display("FAIL rand_rf_we c=%0d: got %b want %b", c, bus.rf_we, m_we);
      end
      if (int'(bus.pend_cnt) != exp_pend() || $isunknown(bus.pend_cnt)) begin
        n_err++; $display("FAIL rand_pend c=%0d: got %0d want %0d", c, bus.pend_cnt, exp_pend());
      end
      if (m_we) begin
        n_cmp++;
        if (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
          n_err++;
          $display("FAIL rand_write c=%0d: got addr=%0d data=%h want addr=%0d data=%h", c,
                   bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata);
        end
      end
      g_prev = g;
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_round_robin();
    test_set_clear();
    test_zero_waw();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
